// File: rtl/iq_envelope_decimator.sv
// I/Q magnitude (alpha-max-plus-beta-min) with window-mean decimation.
// Define IQ_ENVELOPE_PEAK_EN to emit the window maximum instead of the mean.
module iq_envelope_decimator #(
   parameter int NBITS   = 16,
   parameter int DECBITS = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [NBITS-1:0] i_in,
   input  logic [NBITS-1:0] q_in,
   output logic [NBITS-1:0] amplitude,
   output logic             next,
   output logic             sat_flag
);

   localparam int MW = NBITS - 1;
   localparam int CW = (DECBITS > 0) ? DECBITS : 1;
   localparam bit NODEC = (DECBITS == 0);
   localparam logic [MW-1:0] MMAX = '1;
   localparam logic [CW-1:0] CMAX = CW'((1 << DECBITS) - 1);

   // Returns {saturated, |x|}; the most negative code clips to MMAX.
   function automatic logic [MW:0] absv(input logic [NBITS-1:0] x);
      logic [NBITS-1:0] n;
      n = -x;
      if (!x[NBITS-1])
         absv = {1'b0, x[MW-1:0]};
      else if (x[MW-1:0] == '0)
         absv = {1'b1, MMAX};
      else
         absv = {1'b0, n[MW-1:0]};
   endfunction

   logic [MW:0]    ai, aq;
   logic [MW-1:0]  a, b;
   logic           v1, v2;
   logic [MW-1:0]  mx, mn;
   logic [MW+1:0]  msum;
   logic           m_sat;
   logic [MW-1:0]  mclip, m2;
   logic [CW-1:0]  cnt;
   logic           last;
   logic [NBITS-1:0] res;

   assign ai = absv(i_in);
   assign aq = absv(q_in);

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         a  <= '0;
         b  <= '0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            a <= ai[MW-1:0];
            b <= aq[MW-1:0];
         end
      end
   end

   always_comb begin
      mx    = (a > b) ? a : b;
      mn    = (a > b) ? b : a;
      msum  = {2'b00, mx} + {2'b00, mn >> 2} + {2'b00, mn >> 3};
      m_sat = msum > {2'b00, MMAX};
      mclip = m_sat ? MMAX : msum[MW-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v2 <= 1'b0;
         m2 <= '0;
      end else begin
         v2 <= v1;
         if (v1)
            m2 <= mclip;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         sat_flag <= 1'b0;
      else if ((in_valid && (ai[MW] || aq[MW])) || (v1 && m_sat))
         sat_flag <= 1'b1;
   end

   assign last = NODEC || (cnt == CMAX);

`ifdef IQ_ENVELOPE_PEAK_EN
   logic [MW-1:0] pk, pk_nx;

   // A window's first sample replaces whatever the last window left behind.
   assign pk_nx = ((cnt == '0) || (m2 > pk)) ? m2 : pk;
   assign res   = NBITS'(pk_nx);

   always_ff @(posedge clk) begin
      if (rst)
         pk <= '0;
      else if (v2)
         pk <= last ? '0 : pk_nx;
   end
`else
   localparam int AW = MW + DECBITS;
   logic [AW-1:0] acc, acc_nx;

   assign acc_nx = acc + AW'(m2);
   assign res    = NBITS'(acc_nx >> DECBITS);

   always_ff @(posedge clk) begin
      if (rst)
         acc <= '0;
      else if (v2)
         acc <= last ? '0 : acc_nx;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         amplitude <= '0;
         next      <= 1'b0;
      end else begin
         next <= 1'b0;
         if (v2) begin
            if (last) begin
               cnt       <= '0;
               amplitude <= res;
               next      <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_iq_envelope_decimator.sv
// Directed bench for iq_envelope_decimator (NBITS=16, DECBITS=2) against
// a window-level model of magnitude, saturation and pulse timing.
module tb_iq_envelope_decimator;

   localparam int NB = 16;
   localparam int DB = 2;
   localparam int WIN = 1 << DB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [NB-1:0] i_in = '0;
   logic [NB-1:0] q_in = '0;
   logic [NB-1:0] amplitude;
   logic          next;
   logic          sat_flag;

   iq_envelope_decimator #(.NBITS(NB), .DECBITS(DB)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .i_in(i_in), .q_in(q_in),
      .amplitude(amplitude), .next(next), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   bit armed = 0;
   int pulses = 0;

   int exp_next[int];
   int exp_amp = 0;
   int sat_from = -1;
   int win[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic int absclip(input int x);
      int r;
      r = (x < 0) ? -x : x;
      return (r > 32767) ? 32767 : r;
   endfunction

   function automatic int raw_mag(input int i, input int q);
      int a, b, mx, mn;
      a  = absclip(i);
      b  = absclip(q);
      mx = (a > b) ? a : b;
      mn = (a > b) ? b : a;
      return mx + mn / 4 + mn / 8;
   endfunction

   function automatic int mag(input int i, input int q);
      int m;
      m = raw_mag(i, q);
      return (m > 32767) ? 32767 : m;
   endfunction

   function automatic int window_result();
      int r;
      r = 0;
`ifdef IQ_ENVELOPE_PEAK_EN
      foreach (win[n]) if (win[n] > r) r = win[n];
`else
      foreach (win[n]) r += win[n];
      r = r / WIN;
`endif
      return r;
   endfunction

   // One cycle of stimulus; captured at the next rising edge.
   task automatic drive(input bit r, input bit v, input int i, input int q);
      int k;
      @(negedge clk);
      #1;
      k = cyc;
      rst = r;
      in_valid = v;
      i_in = NB'(i);
      q_in = NB'(q);
      if (r) begin
         foreach (exp_next[key]) if (key > k) exp_next.delete(key);
         win.delete();
         exp_amp = 0;
         sat_from = -1;
      end else if (v) begin
         if (sat_from < 0) begin
            if (i == -32768 || q == -32768)
               sat_from = k + 1;
            else if (raw_mag(i, q) > 32767)
               sat_from = k + 2;
         end
         win.push_back(mag(i, q));
         if (win.size() == WIN) begin
            exp_next[k + 3] = window_result();
            win.delete();
         end
      end
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) drive(0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (armed) begin
         if (exp_next.exists(cyc)) begin
            exp_amp = exp_next[cyc];
            exp_next.delete(cyc);
            check("next_pulse", int'(next), 1);
         end else begin
            check("next_quiet", int'(next), 0);
         end
         check("amplitude", int'(amplitude), exp_amp);
         check("sat_flag", int'(sat_flag),
               (sat_from >= 0 && cyc >= sat_from) ? 1 : 0);
         if (next) pulses++;
      end
   end

   int p0;

   initial begin
      repeat (2) @(negedge clk);
      #1;
      check("reset_amp", int'(amplitude), 0);
      check("reset_next", int'(next), 0);
      check("reset_sat", int'(sat_flag), 0);
      armed = 1;

      check("pin_m_3000_4000", mag(3000, 4000), 5125);
      check("pin_m_min_min", mag(-32768, -32768), 32767);
      check("pin_m_-400_300", mag(-400, 300), 512);

      drive(0, 0, 0, 0);
      for (int n = 0; n < 4; n++) drive(0, 1, 3000, 4000);
      idle(5);
      check("t1_amp", int'(amplitude), 5125);
      check("t1_sat", int'(sat_flag), 0);

      for (int n = 0; n < 4; n++) drive(0, 1, -32768, -32768);
      idle(5);
      check("t2_amp", int'(amplitude), 32767);
      check("t2_sat", int'(sat_flag), 1);

      p0 = pulses;
      for (int n = 0; n < 12; n++) drive(0, 1, -400, 300);
      idle(5);
      check("t5_pulses", pulses - p0, 3);
      check("t5_amp", int'(amplitude), 512);
      check("t5_sat_sticky", int'(sat_flag), 1);

      p0 = pulses;
      drive(0, 1, 0, 0);
      idle(2);
      drive(0, 1, 0, 0);
      idle(2);
      drive(0, 1, 8000, 0);
      idle(2);
      drive(0, 1, 8000, 0);
      idle(5);
      check("t4_pulses", pulses - p0, 1);
      check("t4_amp", int'(amplitude), 4000);

      drive(0, 1, 1000, 0);
      drive(0, 1, 1000, 0);
      drive(1, 0, 0, 0);
      p0 = pulses;
      for (int n = 0; n < 4; n++) drive(0, 1, 100, 0);
      idle(5);
      check("t3_pulses", pulses - p0, 1);
      check("t3_amp", int'(amplitude), 100);
      check("t3_sat_cleared", int'(sat_flag), 0);

      drive(0, 1, 100, 0);
      drive(0, 1, 900, 0);
      drive(0, 1, 300, 0);
      drive(0, 1, 50, 0);
      idle(5);
`ifdef IQ_ENVELOPE_PEAK_EN
      check("t6_amp_peak", int'(amplitude), 900);
`else
      check("t6_amp_mean", int'(amplitude), 337);
`endif

      idle(3);
      check("pending_pulses", exp_next.num(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/iq_envelope_decimator.md
Name: iq_envelope_decimator

Overview:
- Upstream feeder for the amplitude averager/peak tracker stage.
- Takes complex baseband samples (I/Q) with a valid strobe and computes an approximate magnitude (alpha-max-plus-beta-min).
- Decimates the magnitude by 2^DECBITS (window mean) and emits one non-negative signed `amplitude` word with a single-cycle `next` strobe per window, matching the averager's input contract.

Parameters:
- NBITS, 16: width of i_in, q_in and amplitude, signed two's complement.
- DECBITS, 5: log2 of the decimation window length; window = 2^DECBITS valid input samples. Legal range 0..12; 0 means no decimation.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  i_in/q_in valid this cycle; may be high every cycle or with arbitrary gaps.
- i_in  input  NBITS  signed in-phase sample.
- q_in  input  NBITS  signed quadrature sample.
- amplitude  output  NBITS  signed, always >= 0; window result; registered; held between windows.
- next  output  1  one-cycle pulse; amplitude is new in this cycle.
- sat_flag  output  1  sticky; set when any magnitude saturated; cleared only by rst.

Behaviour:
- Reset, synchronous, dominates all other inputs: amplitude=0, next=0, sat_flag=0, pipeline valid bits=0, window counter=0, accumulator=0. Reset mid-window discards the partial window; the first window after reset starts with the first valid sample.
- Stage 1, registered on in_valid:
  - a=|i_in|, b=|q_in|, each NBITS-1 bits unsigned.
  - |-2^(NBITS-1)| saturates to 2^(NBITS-1)-1 and sets sat_flag.
  - v1 <= in_valid.
- Stage 2:
  - mx=max(a,b), mn=min(a,b); m = mx + (mn>>2) + (mn>>3), computed in NBITS+1 bits, each shift truncated.
  - If m > 2^(NBITS-1)-1, m := 2^(NBITS-1)-1 and sat_flag <= 1.
  - v2 <= v1.
- Stage 3, when v2=1:
  - acc (NBITS-1+DECBITS bits unsigned) accumulates m; cnt (DECBITS bits) increments.
  - When cnt == 2^DECBITS-1: amplitude <= (acc+m)>>DECBITS (zero-extended to NBITS), next <= 1, acc <= 0, cnt <= 0, wrapping naturally.
  - Otherwise next <= 0.
- Latency: the last sample of a window presented with in_valid at cycle t gives next=1 during cycle t+3. next is never high two consecutive cycles unless DECBITS=0 with back-to-back valid.
- in_valid=0 cycles: no state change beyond the pipeline shifting bubbles; the window spans valid samples only, regardless of gaps.
- DECBITS=0: amplitude = m each valid sample, next follows v2.
- acc never overflows: sized for 2^DECBITS × (2^(NBITS-1)-1).
- No backpressure: the consumer must accept every next pulse.

Optional Feature:
- Macro: IQ_ENVELOPE_PEAK_EN.
- Defined: stage 3 tracks the window maximum instead of the sum; pk <= (first sample of window) ? m : max(pk,m); amplitude <= final max at window end, same timing, same next behaviour; acc replaced by NBITS-1-bit pk register.
- Undefined: window mean as above. Latency, ports and sat_flag are identical in both builds.

Test Plan (NBITS=16, DECBITS=2 unless stated):
- Reset then 4 consecutive valid samples I=3000, Q=4000 -> m=4000+750+375=5125; next pulses once, 3 cycles after the 4th valid; amplitude=5125; sat_flag=0.
- I=Q=-32768 for 4 samples -> abs saturates to 32767, m=32767+8191+4095=45053 clipped to 32767; amplitude=32767, sat_flag=1 and stays 1 through later normal windows until rst.
- 2 valid samples (I=1000, Q=0), rst for 1 cycle, then 4 samples I=100, Q=0 -> exactly one next pulse after reset, amplitude=100; no pulse from the aborted window.
- in_valid high one cycle in three; samples I=Q=0, 0, 8000, 8000 (Q=0) -> m=0,0,8000,8000; amplitude=4000; next 3 cycles after the 4th valid only.
- 12 consecutive valid samples with I=-400, Q=300 -> m=400+75+37=512; 3 next pulses spaced exactly 4 cycles, each amplitude=512.
- With IQ_ENVELOPE_PEAK_EN, 4 samples with m values 100, 900, 300, 50 (Q=0, I=those values) -> amplitude=900; without the macro -> amplitude=337.
